// File: rtl/mc_wb_pkg.sv
// mc_wb_pkg: shared constants for the write-back data register.
//   LD_*    : ld_mode encodings (reserved codes 101-111 behave as LD_W)
//   SRC_*   : default result-source indices into the packed source bus
package mc_wb_pkg;

    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_H  = 3'b001;
    localparam logic [2:0] LD_HU = 3'b010;
    localparam logic [2:0] LD_B  = 3'b011;
    localparam logic [2:0] LD_BU = 3'b100;

    localparam int unsigned SRC_ALU = 0;
    localparam int unsigned SRC_DM  = 1;
    localparam int unsigned SRC_PC4 = 2;
    localparam int unsigned SRC_IMM = 3;

endpackage

// File: rtl/mc_load_ext.sv
// mc_load_ext: combinational load-width extension of a 32-bit memory word.
//   word       in  32      raw data-memory word
//   mode       in  3       load mode (mc_wb_pkg LD_* encoding)
//   offset     in  2       byte offset of the load address
//   ext_val    out DATA_W  extracted lane, sign/zero-extended to DATA_W
//   misaligned out 1       LW with offset != 0, or LH/LHU with offset[0] set
module mc_load_ext
    import mc_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [31:0]       word,
    input  logic [2:0]        mode,
    input  logic [1:0]        offset,
    output logic [DATA_W-1:0] ext_val,
    output logic              misaligned
);

    logic [15:0] w_half;
    logic [7:0]  w_byte;

    // Half lane uses offset[1] only; byte 0 of a misaligned half is ignored.
    assign w_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        w_byte = word[7:0];
        case (offset)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
    end

    always_comb begin
        ext_val    = DATA_W'($signed(word));
        misaligned = (offset != 2'd0);
        case (mode)
            LD_H: begin
                ext_val    = DATA_W'($signed(w_half));
                misaligned = offset[0];
            end
            LD_HU: begin
                ext_val    = DATA_W'(w_half);
                misaligned = offset[0];
            end
            LD_B: begin
                ext_val    = DATA_W'($signed(w_byte));
                misaligned = 1'b0;
            end
            LD_BU: begin
                ext_val    = DATA_W'(w_byte);
                misaligned = 1'b0;
            end
            default: begin
                ext_val    = DATA_W'($signed(word));
                misaligned = (offset != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/mc_wb_data_reg.sv
// mc_wb_data_reg: write-back data register between ALU/DM and the register file.
//   CLK       in  1             rising-edge clock
//   Reset     in  1             synchronous, active-low reset
//   src_data  in  SRC_N*DATA_W  packed result sources, source i at [i*DATA_W +: DATA_W]
//   src_sel   in  SEL_W         source select (out-of-range selects 0)
//   ld_mode   in  3             load mode for the DM source
//   addr_lo   in  2             byte offset of the load address
//   cap_en    in  1             capture request
//   wb_ack    in  1             consumer has taken DBOut
//   DBOut     out DATA_W        held write-back value
//   out_valid out 1             DBOut holds unconsumed data
//   misalign  out 1             last capture was a misaligned load
//   overflow  out 1             sticky: capture arrived while data was unconsumed
module mc_wb_data_reg
    import mc_wb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SRC_N  = 4,
    parameter int unsigned DM_SRC = SRC_DM,
    parameter int unsigned SEL_W  = $clog2(SRC_N)
) (
    input  logic                    CLK,
    input  logic                    Reset,
    input  logic [SRC_N*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]        src_sel,
    input  logic [2:0]              ld_mode,
    input  logic [1:0]              addr_lo,
    input  logic                    cap_en,
    input  logic                    wb_ack,
    output logic [DATA_W-1:0]       DBOut,
    output logic                    out_valid,
    output logic                    misalign,
    output logic                    overflow
);

    logic [DATA_W-1:0] w_sel_val;
    logic [DATA_W-1:0] w_ext_val;
    logic              w_ext_mis;
    logic              w_is_dm;
    logic [DATA_W-1:0] w_load_val;
    logic              w_load_mis;
    logic              w_accept;

    logic [DATA_W-1:0] r_db;
    logic              r_valid;
    logic              r_mis;
    logic              r_ovf;

    // Indices >= SRC_N never match, leaving the zero default.
    always_comb begin
        w_sel_val = '0;
        for (int unsigned i = 0; i < SRC_N; i++) begin
            if (32'(src_sel) == i) begin
                w_sel_val = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_is_dm = (32'(src_sel) == DM_SRC);

    mc_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .word       (w_sel_val[31:0]),
        .mode       (ld_mode),
        .offset     (addr_lo),
        .ext_val    (w_ext_val),
        .misaligned (w_ext_mis)
    );

    assign w_load_val = w_is_dm ? w_ext_val : w_sel_val;
    assign w_load_mis = w_is_dm & w_ext_mis;

    // A capture loads only if the slot is free or being consumed this cycle.
    assign w_accept = ~r_valid | wb_ack;

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_db    <= '0;
            r_valid <= 1'b0;
            r_mis   <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (cap_en) begin
            if (w_accept) begin
                r_db    <= w_load_val;
                r_valid <= 1'b1;
                r_mis   <= w_load_mis;
            end else begin
                r_ovf   <= 1'b1;
            end
        end else if (wb_ack) begin
            r_valid <= 1'b0;
        end
    end

    assign DBOut     = r_db;
    assign out_valid = r_valid;
    assign misalign  = r_mis;
    assign overflow  = r_ovf;

endmodule

// File: tb/tb_mc_wb_data_reg.sv
// tb_mc_wb_data_reg: scoreboard bench driving a default (32-bit, 4-source)
// instance and a 64-bit, 3-source instance with shared control inputs.
module tb_mc_wb_data_reg;

    logic         CLK = 1'b0;
    logic         Reset;
    logic [1:0]   src_sel;
    logic [2:0]   ld_mode;
    logic [1:0]   addr_lo;
    logic         cap_en;
    logic         wb_ack;
    logic [127:0] src32;
    logic [191:0] src64;

    logic [31:0]  db32;
    logic         v32, m32, o32;
    logic [63:0]  db64;
    logic         v64, m64, o64;

    logic [63:0]  s32 [0:3];
    logic [63:0]  s64 [0:3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] db [2];
        bit          v  [2];
        bit          m  [2];
        bit          o  [2];
    } exp_t;

    exp_t sbq [$];

    logic [63:0] mdb [2];
    bit          mv  [2];
    bit          mm  [2];
    bit          mo  [2];

    always #5 CLK = ~CLK;

    mc_wb_data_reg u_dut32 (
        .CLK       (CLK),
        .Reset     (Reset),
        .src_data  (src32),
        .src_sel   (src_sel),
        .ld_mode   (ld_mode),
        .addr_lo   (addr_lo),
        .cap_en    (cap_en),
        .wb_ack    (wb_ack),
        .DBOut     (db32),
        .out_valid (v32),
        .misalign  (m32),
        .overflow  (o32)
    );

    mc_wb_data_reg #(
        .DATA_W (64),
        .SRC_N  (3)
    ) u_dut64 (
        .CLK       (CLK),
        .Reset     (Reset),
        .src_data  (src64),
        .src_sel   (src_sel),
        .ld_mode   (ld_mode),
        .addr_lo   (addr_lo),
        .cap_en    (cap_en),
        .wb_ack    (wb_ack),
        .DBOut     (db64),
        .out_valid (v64),
        .misalign  (m64),
        .overflow  (o64)
    );

    // Reference: value a capture would load, built from the load rules directly.
    function automatic void ref_val(input logic [63:0] src [0:3], input int srcn,
                                    input int sel, input int mode, input int off,
                                    input int dw, output logic [63:0] val,
                                    output bit mis);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        val = (sel < srcn) ? src[sel] : 64'd0;
        mis = 1'b0;
        if (sel == 1) begin
            w = val[31:0];
            h = 16'(w >> (16 * (off / 2)));
            b = 8'(w >> (8 * off));
            case (mode)
                1: begin val = {{48{h[15]}}, h}; mis = (off % 2 == 1); end
                2: begin val = {48'd0, h};       mis = (off % 2 == 1); end
                3: begin val = {{56{b[7]}}, b};  mis = 1'b0; end
                4: begin val = {56'd0, b};       mis = 1'b0; end
                default: begin val = {{32{w[31]}}, w}; mis = (off != 0); end
            endcase
        end
        if (dw == 32) val[63:32] = 32'd0;
    endfunction

    task automatic step(input bit rst, input int sel, input int mode, input int off,
                        input bit cap, input bit ack);
        logic [63:0] val;
        bit          mis;
        exp_t        e;
        int          tmp_sel;
        int          tmp_mode;
        int          tmp_off;
        tmp_sel  = sel;
        tmp_mode = mode;
        tmp_off  = off;
        Reset   = rst;
        src_sel = tmp_sel[1:0];
        ld_mode = tmp_mode[2:0];
        addr_lo = tmp_off[1:0];
        cap_en  = cap;
        wb_ack  = ack;
        src32   = {s32[3][31:0], s32[2][31:0], s32[1][31:0], s32[0][31:0]};
        src64   = {s64[2], s64[1], s64[0]};
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) ref_val(s32, 4, sel, mode, off, 32, val, mis);
            else        ref_val(s64, 3, sel, mode, off, 64, val, mis);
            if (!rst) begin
                mdb[k] = '0; mv[k] = 0; mm[k] = 0; mo[k] = 0;
            end else if (cap) begin
                if (!mv[k] || ack) begin
                    mdb[k] = val; mv[k] = 1; mm[k] = mis;
                end else begin
                    mo[k] = 1;
                end
            end else if (ack) begin
                mv[k] = 0;
            end
            e.db[k] = mdb[k];
            e.v[k]  = mv[k];
            e.m[k]  = mm[k];
            e.o[k]  = mo[k];
        end
        sbq.push_back(e);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("db32",  {32'd0, db32}, e.db[0]);
            chk("v32",   64'(v32),      64'(e.v[0]));
            chk("mis32", 64'(m32),      64'(e.m[0]));
            chk("ovf32", 64'(o32),      64'(e.o[0]));
            chk("db64",  db64,          e.db[1]);
            chk("v64",   64'(v64),      64'(e.v[1]));
            chk("mis64", 64'(m64),      64'(e.m[1]));
            chk("ovf64", 64'(o64),      64'(e.o[1]));
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            mdb[k] = '0; mv[k] = 0; mm[k] = 0; mo[k] = 0;
        end
        s32[0] = 64'h1234_5678;
        s32[1] = 64'h80FF_7F01;
        s32[2] = 64'h0000_0004;
        s32[3] = 64'hCAFE_0001;
        s64[0] = 64'h0123_4567_89AB_CDEF;
        s64[1] = 64'hA5A5_A5A5_8000_7F9C;
        s64[2] = 64'h0000_0000_0000_0008;
        s64[3] = 64'hFFFF_FFFF_FFFF_FFFF;

        // reset held with capture requested
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        // ALU capture then consume
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
        // load extension lanes
        step(1, 1, 3, 3, 1, 0);
        step(1, 1, 4, 3, 1, 1);
        step(1, 1, 1, 2, 1, 1);
        step(1, 1, 2, 0, 1, 1);
        // misaligned LW, then aligned LB
        step(1, 1, 0, 2, 1, 1);
        step(1, 1, 3, 0, 1, 1);
        step(1, 0, 0, 0, 0, 1);
        // out-of-range select on the 3-source instance
        step(1, 3, 0, 0, 1, 0);
        // capture without ack -> overflow, then ack keeps overflow
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1);
        // mid-operation reset with capture and ack asserted
        step(0, 1, 0, 1, 1, 1);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    s32[i] = {32'd0, $urandom()};
                    s64[i] = {$urandom(), $urandom()};
                end
            end
            step(($urandom_range(0, 39) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        cap_en = 1'b0;
        wb_ack = 1'b0;

        @(negedge CLK);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
